// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path: widths, requester ids
// and the write-request record.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr_q,
// pointer advances past the winner on every grant.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         win_idx,
  output logic               gnt_any
);
  logic [1:0]           ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [2:0]           off, sum;

  always_comb begin
    // Rotate so bit 0 of rot is the requester at ptr_q; lowest set bit wins.
    dbl     = {req_valid, req_valid} >> ptr_q;
    rot     = dbl[NUM_REQ-1:0];
    off     = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        off     = 3'(k);
      end
    end
    if (rst) gnt_any = 1'b0;
    sum = {1'b0, ptr_q} + off;
    if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
    win_idx = sum[1:0];
    grant   = gnt_any ? (NUM_REQ'(1) << win_idx) : '0;
    ptr_d   = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr_q <= '0;
    else if (gnt_any) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources.
// Optional X0_DROP_EN: granted writes to x0 complete but never raise RegWrite.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int AW      = rf_pkg::AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    RegWrite,
  output logic [AW-1:0]           A3,
  output logic [XLEN-1:0]         WD3,
  output logic [1:0]              grant_id,
  output logic [15:0]             collision_cnt
);
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } req_t;

  req_t       reqs [NUM_REQ];
  req_t       sel;
  logic [1:0] win;
  logic       gnt_any;
  logic [2:0] nvalid;
  logic       we_d, we_q;
  logic [AW-1:0]   a3_q;
  logic [XLEN-1:0] wd3_q;
  logic [1:0]      gid_q;
  logic [15:0]     cnt_d, cnt_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant     (req_ready),
    .win_idx   (win),
    .gnt_any   (gnt_any)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reqs[g] = {req_addr[g*AW +: AW], req_data[g*XLEN +: XLEN]};
  end

  always_comb begin
    sel    = '0;
    nvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 2'(i)) sel = reqs[i];
      nvalid = nvalid + 3'(req_valid[i]);
    end
`ifdef X0_DROP_EN
    we_d = gnt_any && (sel.addr != '0);
`else
    we_d = gnt_any;
`endif
    // Saturating count of cycles where two or more sources contend.
    cnt_d = cnt_q;
    if (nvalid >= 3'd2 && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      gid_q <= '0;
      cnt_q <= '0;
    end else begin
      we_q  <= we_d;
      cnt_q <= cnt_d;
      if (gnt_any) begin
        a3_q  <= sel.addr;
        wd3_q <= sel.data;
        gid_q <= win;
      end
    end
  end

  assign RegWrite      = we_q;
  assign A3            = a3_q;
  assign WD3           = wd3_q;
  assign grant_id      = gid_q;
  assign collision_cnt = cnt_q;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port (RegWrite, A3, WD3) among several writeback requesters, for example ALU result, load data and debug/CSR writes. Selects one requester per cycle by round-robin using a valid/ready handshake. Drives the register file write port from registers, and counts write-port collisions for performance monitoring. Sits between the writeback sources and the register file; the read ports are not involved.

## Interface
- NUM_REQ, 3, number of write requesters (2..4)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*AW  packed destination register, requester i at bits [i*AW +: AW]
- req_data  in  NUM_REQ*XLEN  packed write data, requester i at bits [i*XLEN +: XLEN]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- RegWrite  out  1  register file write enable, registered
- A3  out  AW  register file write address, registered
- WD3  out  XLEN  register file write data, registered
- grant_id  out  2  index of the requester currently driving the write port, registered
- collision_cnt  out  16  saturating count of cycles with two or more requests valid

## Operation
- Handshake: a transfer occurs for requester i when req_valid[i] && req_ready[i]. A requester holds valid, addr and data stable until ready. The arbiter never drops a request.
- Arbitration:
  - Round-robin pointer ptr, ranging 0..NUM_REQ-1.
  - The winner is the first valid index found searching ptr, ptr+1, … modulo NUM_REQ.
  - req_ready is one-hot on the winner, or all zero if nothing is valid.
- Pointer update: on a grant, ptr <= (winner+1) mod NUM_REQ. With no grant, ptr is unchanged.
- Write port, updated every cycle:
  - RegWrite <= any grant.
  - On a grant, A3/WD3/grant_id <= the winner's addr/data/index.
  - With no grant, A3/WD3/grant_id hold their values and only RegWrite drops.
- Collision counter: increments when popcount(req_valid) >= 2 and rst is low. It saturates at 16'hFFFF with no wrap.
- Ordering: writes to the same register from different requesters reach the register file in grant order. The last grant wins.
- Reset:
  - While rst=1, req_ready = 0 (forced combinationally) and no transfer occurs.
  - On a clock edge with rst=1: ptr=0, RegWrite=0, A3=0, WD3=0, grant_id=0, collision_cnt=0.
  - A request pending at reset remains pending and is arbitrated from ptr=0 after rst falls.

## Timing
- Grant is decided in the same cycle as valid; req_ready has a zero-cycle path from req_valid.
- Handshake in cycle N puts RegWrite=1 with A3/WD3 during cycle N+1. The register file captures the write at the end of N+1.
- Throughput: one write per cycle, sustained.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of asserting valid.
- Back-to-back grants to the same requester are allowed only when it is the sole valid requester.

## Configuration
- X0_DROP_EN defined:
  - A granted request with addr == 0 completes its handshake normally and advances ptr.
  - RegWrite stays 0 for that slot; A3/WD3/grant_id still update.
  - Guarantees x0 is never written regardless of register file behaviour.
- X0_DROP_EN undefined: an addr == 0 write is forwarded with RegWrite=1, and the register file is responsible for protecting x0.
- Collision counting is identical in both builds.

## Structure
- Shared package rf_pkg:
  - XLEN and AW constants.
  - Requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_DBG=2.
  - A write-request struct typedef {addr, data}.
- Sub-module rr_arbiter, combinational plus pointer register:
  - Inputs: req_valid, rst, clk.
  - Outputs: one-hot grant and winner index.
  - regfile_write_arbiter instantiates it and owns the write-port registers and collision_cnt.

## Test plan
- Single request: reset, then req_valid=3'b001, addr=5, data=32'hDEADBEEF for one cycle. Expect req_ready=3'b001 that cycle, then next cycle RegWrite=1, A3=5, WD3=32'hDEADBEEF, grant_id=0; the cycle after, RegWrite=0.
- Round-robin under full load: all three valid continuously from ptr=0. Expect grant order 0,1,2,0,1,2, RegWrite=1 every cycle, and collision_cnt incrementing by 1 per cycle.
- Same register, two sources: REQ_ALU writes x7=1 and REQ_LOAD writes x7=2, both valid at ptr=0. Expect A3=7/WD3=1, then A3=7/WD3=2; x7 reads 2 afterwards.
- Reset mid-operation: all valid, assert rst for one cycle after two grants. Expect req_ready=0 and RegWrite=0 after the edge, collision_cnt=0 and ptr=0; the next grant goes to requester 0.
- Saturation: preload by holding two requests valid for 65540 cycles. Expect collision_cnt=16'hFFFF with no wrap.
- X0 filtering: req_valid=3'b100, addr=0, data=32'h1234.
  - With X0_DROP_EN: ready asserts, RegWrite stays 0, grant_id=2.
  - Without it: RegWrite=1, A3=0.
